// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 non-restoring divider.
// Holds the FSM state encoding, the default width and the divide-by-zero quotient.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_W = 8;

  // Sliced to W bits at the use site; W never exceeds 32.
  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the arithmetic unit and seq_divider.
// The requester drives the master side; the divider implements the slave side.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int W = DIV_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {A,Q} left, add or subtract M,
// and shift the new quotient bit in from the sign of the updated A.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic [W:0]   m,
  output logic [W:0]   a_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shift_a_s;

  // Add/subtract decision uses the sign of A before the shift.
  always_comb begin
    shift_a_s = {a[W-1:0], q[W-1]};
    a_next    = shift_a_s;
    q_next    = q;
    if (a[W] == 1'b0) begin
      a_next = shift_a_s - m;
    end else begin
      a_next = shift_a_s + m;
    end
    q_next = {q[W-2:0], ~a_next[W]};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 non-restoring unsigned divider, one quotient bit per clock.
// Holds the FSM, iteration counter and registered results; the datapath step is div_step.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic        clk,
  input  logic        rst_b,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(W) + 1;

  div_state_e    state_r, state_s;
  logic [W:0]    a_r, a_s;
  logic [W:0]    m_r, m_s;
  logic [W-1:0]  q_r, q_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          zero_r, zero_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [W-1:0]  quot_r, quot_s;
  logic [W-1:0]  rem_r, rem_s;
  logic          dbz_r, dbz_s;

  logic [W:0]    step_a_s;
  logic [W-1:0]  step_q_s;
  logic [W-1:0]  fix_rem_s;

  div_step #(.W(W)) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (step_a_s),
    .q_next (step_q_s)
  );

  // Final restore: only the low W bits of A survive, so modular add is enough.
  always_comb begin
    fix_rem_s = a_r[W-1:0];
    if (a_r[W] == 1'b1) begin
      fix_rem_s = a_r[W-1:0] + m_r[W-1:0];
    end else begin
      fix_rem_s = a_r[W-1:0];
    end
  end

  // Next-state and next-register logic; a divide-by-zero parks the dividend in Q.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    m_s     = m_r;
    q_s     = q_r;
    cnt_s   = cnt_r;
    zero_s  = zero_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    quot_s  = quot_r;
    rem_s   = rem_r;
    dbz_s   = dbz_r;
    case (state_r)
      IDLE: begin
        if (bus.start == 1'b1) begin
          busy_s = 1'b1;
          cnt_s  = {CW{1'b0}};
          q_s    = bus.dividend;
          a_s    = {(W+1){1'b0}};
          if (bus.divisor == {W{1'b0}}) begin
            zero_s  = 1'b1;
            m_s     = {(W+1){1'b0}};
            state_s = FIX;
          end else begin
            zero_s  = 1'b0;
            m_s     = {1'b0, bus.divisor};
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        a_s   = step_a_s;
        q_s   = step_q_s;
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(W - 1)) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
        if (zero_r == 1'b1) begin
          quot_s = DBZ_QUOT[W-1:0];
          rem_s  = q_r;
          dbz_s  = 1'b1;
        end else begin
          quot_s = q_r;
          rem_s  = fix_rem_s;
          dbz_s  = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and clears results.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= IDLE;
      a_r     <= {(W+1){1'b0}};
      m_r     <= {(W+1){1'b0}};
      q_r     <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quot_r  <= {W{1'b0}};
      rem_r   <= {W{1'b0}};
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      m_r     <= m_s;
      q_r     <= q_s;
      cnt_r   <= cnt_s;
      zero_r  <= zero_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      quot_r  <= quot_s;
      rem_r   <= rem_s;
      dbz_r   <= dbz_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at W=8: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.W(W)) bus ();
  seq_divider #(.W(W)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.z = 1'b1; e.due = acc + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.due = acc + W + 1;
    end
    return e;
  endfunction

  function automatic exp_t hand(input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int due);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.due = due;
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation with a hand-computed expectation; returns at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    sb.push_back(hand(eq, er, ez, cyc + 1 + ((b == 8'd0) ? 1 : W + 1)));
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = 8'h5A; bus.divisor = 8'hA5;
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_b && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(mon_e.q));
        chk("remainder", 32'(bus.remainder), 32'(mon_e.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.z));
        chk("latency_edge", 32'(cyc), 32'(mon_e.due));
        chk("busy_with_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin
    int n;
    int d0;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk) rst_b = 1'b1;

    // 100/7 with busy window length check: busy high on edges k..k+8.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd9);

    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    issue(8'd200, 8'd200, 8'd1, 8'd0, 1'b0);
    issue(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);
    issue(8'd37, 8'd5, 8'd7, 8'd2, 1'b0);

    // Start pulsed with 9/3 mid-CALC must be ignored.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;

    // Start held high through done: second operand set accepted at the edge after done.
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd6;
    sb.push_back(hand(8'd8, 8'd2, 1'b0, cyc + 1 + W + 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 50);
    if (!bus.done) chk("held_done_timeout", 32'd1, 32'd0);
    bus.dividend = 8'd81; bus.divisor = 8'd9;
    sb.push_back(hand(8'd9, 8'd0, 1'b0, cyc + 1 + W + 1));
    @(negedge clk);
    bus.start = 1'b0;

    // Asynchronous reset at CALC step 4 aborts 100/7 with no done afterwards.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_quotient", 32'(bus.quotient), 32'd0);
    chk("arst_remainder", 32'(bus.remainder), 32'd0);
    chk("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    sb.delete();
    d0 = done_cnt;
    @(negedge clk) rst_b = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    // Small random sweep against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 10 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      @(negedge clk);
      wait_idle();
      bus.start = 1'b1; bus.dividend = ra; bus.divisor = rb;
      sb.push_back(model(ra, rb, cyc + 1));
      @(negedge clk);
      bus.start = 1'b0;
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
